vga_scan: RTL and testbench
===========================

// Module: vga_scan
// PURPOSE
//  VGA 640x480@60 raster generator. Sits downstream of the PPU frame buffer (vga_fb).
//  Scans the display, drives pix_ptr_x/pix_ptr_y into the frame buffer and takes back its registered RGB.
//  Shows the 256x240 NES image 2x scaled as a 512x480 window, centred horizontally.
//  Emits delay-aligned sync/blank plus frame_start and vblank to the PPU.
// PARAMETERS
//  H_ACTIVE 640 | H_FP 16 | H_SYNC 96 | H_BP 48   horizontal timing, pix_clk cycles
//  V_ACTIVE 480 | V_FP 10 | V_SYNC 2  | V_BP 33   vertical timing, lines
//  X_OFFSET   64        first active column of the 512-wide window
//  FB_LAT     1         frame-buffer read latency, pix_clk cycles (>=1)
//  BORDER_RGB 9'h003    RRRGGGBBB colour of active-but-outside-window pixels (border build only)
// PORTS
//  pix_clk      in   1  pixel clock (25.175 MHz); only clock
//  rst          in   1  asynchronous, active-high reset
//  pix_ptr_x    out  8  frame-buffer column 0..255
//  pix_ptr_y    out  8  frame-buffer row 0..239
//  rgb_in       in   9  RRRGGGBBB from frame buffer, valid FB_LAT cycles after the pointers
//  vga_rgb      out  9  RRRGGGBBB to DAC
//  hsync_n      out  1  horizontal sync, active low
//  vsync_n      out  1  vertical sync, active low
//  vga_blank_n  out  1  high during the 640x480 active area
//  frame_start  out  1  1-cycle pulse at raster (0,0), undelayed
//  vblank       out  1  high while vcount >= V_ACTIVE, undelayed
// BEHAVIOUR
//  - Reset (async assert) values: hcount=0, vcount=0, vga_rgb=0, hsync_n=1, vsync_n=1,
//    vga_blank_n=0, frame_start=0, vblank=0, delay line cleared to the inactive state.
//  - Scan restarts at (0,0) on the first pix_clk edge after reset deasserts.
//    frame_start pulses on that edge.
//  - hcount counts 0..H_TOT-1 (H_TOT=800), then wraps to 0.
//  - vcount increments when hcount==H_TOT-1. It wraps V_TOT-1 (524) -> 0 on that same edge.
//  - Stage-0 decode, from registered counters:
//      hs = hcount in [656,751]
//      vs = vcount in [490,491]
//      act = hcount<640 && vcount<480
//      win = act && hcount in [X_OFFSET, X_OFFSET+511]
//  - Pointers are combinational from the counters:
//      pix_ptr_x = win ? (hcount-X_OFFSET)>>1 : 0   (9-bit subtract, result truncated to 8 bits)
//      pix_ptr_y = vcount<480 ? vcount>>1 : 239      (never exceeds 239)
//  - hs/vs/act/win pass through a FB_LAT-deep shift register, then one output register.
//    Total latency, counter value -> pins, is FB_LAT+1 cycles.
//  - rgb_in is captured in the same output register, so colour and sync stay aligned.
//  - vga_rgb = win_d ? rgb_in : 0. Forced to 0 whenever act_d=0 (blanking).
//  - frame_start is registered: high for one cycle when next state is (0,0).
//  - vblank is registered from the next vcount.
//  - Reset mid-line or mid-frame: everything returns to reset values immediately.
//    No partial-frame state survives.
// CONFIGURATION
//  - Macro VGA_SCAN_BORDER_EN.
//  - Defined: active pixels with win_d=0 output BORDER_RGB.
//  - Undefined: those pixels output 0 and BORDER_RGB is unused.
//  - Sync, blank and latency are identical in both builds.
// STRUCTURE
//  - Package vga_pkg holds:
//      typedef logic [8:0] rgb9_t
//      localparams for 640x480 timing (H_TOT, V_TOT, sync start/end)
//      NES_W=256, NES_H=240
//  - Sub-module vga_delay_line #(WIDTH, DEPTH): async-reset shift register, used for {hs,vs,act,win}.
// TESTING
//  1. Hold rst for 5 cycles -> all outputs at reset values. Release -> frame_start=1 on first edge, hcount=0.
//  2. Line timing, FB_LAT=1 -> hsync_n falls 658 cycles after frame_start, stays low 96 cycles.
//     Period is 800 cycles.
//  3. Frame timing -> vsync_n low for exactly 2 lines (1600 cycles).
//     frame_start period is 420000 cycles. vblank rises at line 480.
//  4. Pointer mapping:
//      hcount 63 -> x=0 with win=0
//      hcount 64/65 -> x=0
//      hcount 66 -> x=1
//      hcount 575 -> x=255
//      vcount 479 -> y=239
//  5. Bench model of the FB returns {1'b0, pix_ptr_x} after 1 cycle -> vga_rgb equals that value,
//     aligned with vga_blank_n. vga_rgb=0 in blanking, and 0 (or BORDER_RGB with VGA_SCAN_BORDER_EN)
//     in columns 0..63 and 576..639.
//  6. Assert rst at hcount=300, vcount=100 -> outputs reset asynchronously.
//     After release the scan restarts at (0,0) with frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and 640x480@60 timing constants for the VGA raster generator.
package vga_pkg;

  typedef logic [8:0] rgb9_t;

  localparam int CNT_W = 10;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_TOT        = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int V_TOT        = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
  localparam int H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + VGA_H_SYNC - 1;
  localparam int V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + VGA_V_SYNC - 1;

  localparam int NES_W = 256;
  localparam int NES_H = 240;

  function automatic logic in_span(input logic [CNT_W-1:0] val, input int lo, input int hi);
    return (val >= CNT_W'(lo)) && (val <= CNT_W'(hi));
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Async-reset shift register that aligns the sync/blank decode with frame-buffer read latency.
module vga_delay_line #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 1
) (
  input  logic             pix_clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      // NOTE: these are a handful of flops, not a RAM, so clearing every stage is cheap and keeps sync inactive after reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_scan.sv
// VGA raster generator showing the 256x240 NES image 2x scaled in a centred 512x480 window.
// Build option: define VGA_SCAN_BORDER_EN to paint active pixels outside the window with BORDER_RGB.
module vga_scan
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int X_OFFSET = 64,
  parameter int FB_LAT   = 1
`ifdef VGA_SCAN_BORDER_EN
  ,parameter rgb9_t BORDER_RGB = 9'h003
`endif
) (
  input  logic       pix_clk,
  input  logic       rst,
  output logic [7:0] pix_ptr_x,
  output logic [7:0] pix_ptr_y,
  input  rgb9_t      rgb_in,
  output rgb9_t      vga_rgb,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       vga_blank_n,
  output logic       frame_start,
  output logic       vblank
);

  localparam int LINE_LEN  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int FRAME_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO     = H_ACTIVE + H_FP;
  localparam int HS_HI     = HS_LO + H_SYNC - 1;
  localparam int VS_LO     = V_ACTIVE + V_FP;
  localparam int VS_HI     = VS_LO + V_SYNC - 1;
  localparam int WIN_LO    = X_OFFSET;
  localparam int WIN_HI    = X_OFFSET + 2 * NES_W - 1;

  logic             run;
  logic [CNT_W-1:0] hcount, vcount;
  logic [CNT_W-1:0] h_next, v_next;
  logic             hs, vs, act, win;
  logic             hs_d, vs_d, act_d, win_d;
  logic [3:0]       dly_q;
  logic [8:0]       hoff;
  rgb9_t            pix;

  // The first edge after reset holds (0,0) so frame_start can mark it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    h_next = '0;
    v_next = '0;
    if (run) begin
      if (hcount == CNT_W'(LINE_LEN - 1)) begin
        v_next = (vcount == CNT_W'(FRAME_LEN - 1)) ? '0 : vcount + 1'b1;
      end else begin
        h_next = hcount + 1'b1;
        v_next = vcount;
      end
    end
  end

  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      run         <= 1'b0;
      hcount      <= '0;
      vcount      <= '0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge values, independent of statement order.
      run         <= 1'b1;
      hcount      <= h_next;
      vcount      <= v_next;
      frame_start <= (h_next == '0) && (v_next == '0);
      vblank      <= v_next >= CNT_W'(V_ACTIVE);
    end
  end

  assign hs  = run && in_span(hcount, HS_LO, HS_HI);
  assign vs  = run && in_span(vcount, VS_LO, VS_HI);
  assign act = run && (hcount < CNT_W'(H_ACTIVE)) && (vcount < CNT_W'(V_ACTIVE));
  assign win = act && in_span(hcount, WIN_LO, WIN_HI);

  assign hoff      = hcount[8:0] - 9'(X_OFFSET);
  assign pix_ptr_x = win ? 8'(hoff >> 1) : '0;
  assign pix_ptr_y = (vcount < CNT_W'(V_ACTIVE)) ? 8'(vcount >> 1) : 8'(NES_H - 1);

  vga_delay_line #(
    .WIDTH (4),
    .DEPTH (FB_LAT)
  ) u_dly (
    .pix_clk (pix_clk),
    .rst     (rst),
    .d       ({hs, vs, act, win}),
    .q       (dly_q)
  );

  assign {hs_d, vs_d, act_d, win_d} = dly_q;

  always_comb begin
    pix = '0;
    if (win_d) begin
      pix = rgb_in;
    end
`ifdef VGA_SCAN_BORDER_EN
    else if (act_d) begin
      pix = BORDER_RGB;
    end
`endif
  end

  // Colour and sync share one output register so they leave the chip aligned.
  always_ff @(posedge pix_clk or posedge rst) begin
    if (rst) begin
      vga_rgb     <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_rgb     <= pix;
      hsync_n     <= ~hs_d;
      vsync_n     <= ~vs_d;
      vga_blank_n <= act_d;
    end
  end

endmodule

// File: tb/tb_vga_scan.sv
// Self-checking bench for vga_scan against a cycle-index raster model; the vertical raster
// is shortened (20 active lines, 27 total) so whole frames fit in a short run.
module tb_vga_scan;

  localparam int LINE  = 800;
  localparam int VA    = 20;
  localparam int VFP   = 2;
  localparam int VSY   = 2;
  localparam int VBP   = 3;
  localparam int VT    = VA + VFP + VSY + VBP;
  localparam int FRAME = LINE * VT;
`ifdef VGA_SCAN_BORDER_EN
  localparam bit BORDER = 1'b1;
`else
  localparam bit BORDER = 1'b0;
`endif

  logic       pix_clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pix_ptr_x, pix_ptr_y;
  logic [8:0] rgb_in = '0;
  logic [8:0] vga_rgb;
  logic       hsync_n, vsync_n, vga_blank_n, frame_start, vblank;

  int checks = 0;
  int errors = 0;
  bit fb_mode = 1'b0;
  logic [8:0] fb_img [240][256];

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [8:0] rgb;
    logic       hs_n;
    logic       vs_n;
    logic       blank_n;
    logic       fs;
    logic       vb;
  } obs_t;

  vga_scan #(
    .V_ACTIVE (VA),
    .V_FP     (VFP),
    .V_SYNC   (VSY),
    .V_BP     (VBP)
  ) dut (
    .pix_clk     (pix_clk),
    .rst         (rst),
    .pix_ptr_x   (pix_ptr_x),
    .pix_ptr_y   (pix_ptr_y),
    .rgb_in      (rgb_in),
    .vga_rgb     (vga_rgb),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .vga_blank_n (vga_blank_n),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  always #5 pix_clk = ~pix_clk;

  // Frame-buffer model with one cycle of read latency.
  always @(posedge pix_clk)
    rgb_in <= fb_mode ? fb_img[pix_ptr_y][pix_ptr_x] : {1'b0, pix_ptr_x};

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  function automatic obs_t observe();
    obs_t o;
    o.x = pix_ptr_x; o.y = pix_ptr_y; o.rgb = vga_rgb;
    o.hs_n = hsync_n; o.vs_n = vsync_n; o.blank_n = vga_blank_n;
    o.fs = frame_start; o.vb = vblank;
    return o;
  endfunction

  // Expected pins k cycles after the frame_start edge; pins show raster position k-2.
  function automatic obs_t model(input int k, input int img_from);
    obs_t e;
    int h, v, c, hc, vc, x, y;
    bit act, win;
    h = k % LINE;
    v = (k / LINE) % VT;
    win = (h >= 64) && (h <= 575) && (v < VA);
    e.x = win ? 8'((h - 64) / 2) : 8'd0;
    e.y = (v < VA) ? 8'(v / 2) : 8'd239;
    e.fs = (k % FRAME) == 0;
    e.vb = v >= VA;
    e.hs_n = 1'b1; e.vs_n = 1'b1; e.blank_n = 1'b0; e.rgb = '0;
    if (k >= 2) begin
      c  = k - 2;
      hc = c % LINE;
      vc = (c / LINE) % VT;
      act = (hc < 640) && (vc < VA);
      win = act && (hc >= 64) && (hc <= 575);
      e.hs_n = !((hc >= 656) && (hc <= 751));
      e.vs_n = !((vc >= VA + VFP) && (vc < VA + VFP + VSY));
      e.blank_n = act;
      if (win) begin
        x = (hc - 64) / 2;
        y = vc / 2;
        e.rgb = (c >= img_from) ? fb_img[y][x] : {1'b0, 8'(x)};
      end else if (act && BORDER) begin
        e.rgb = 9'h003;
      end
    end
    return e;
  endfunction

  // Leaves the bench at the sampling point just after the first scan edge (cycle 0).
  task automatic do_reset(input int hold);
    @(negedge pix_clk);
    rst = 1'b1;
    repeat (hold) @(negedge pix_clk);
    rst = 1'b0;
    @(negedge pix_clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(negedge pix_clk);
    checks++; if (vga_rgb !== 9'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", vga_rgb); end
    checks++; if (hsync_n !== 1'b1) begin errors++; $display("FAIL reset_hsync_n: got %b expected 1", hsync_n); end
    checks++; if (vsync_n !== 1'b1) begin errors++; $display("FAIL reset_vsync_n: got %b expected 1", vsync_n); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b expected 0", vga_blank_n); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (vblank !== 1'b0) begin errors++; $display("FAIL reset_vblank: got %b expected 0", vblank); end
    rst = 1'b0;
    @(negedge pix_clk);
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL first_frame_start: got %b expected 1", frame_start); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL first_blank_n: got %b expected 0", vga_blank_n); end
    @(negedge pix_clk);
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width: got %b expected 0", frame_start); end
  endtask

  task automatic test_pointer_map();
    logic [8:0] side;
    side = BORDER ? 9'h003 : 9'h000;
    fb_mode = 1'b0;
    do_reset(3);
    for (int k = 0; k <= 600; k++) begin
      if (k == 63 || k == 64 || k == 65 || k == 66 || k == 575 || k == 576) begin
        checks++;
        if (pix_ptr_x !== ((k == 66) ? 8'd1 : (k == 575) ? 8'd255 : 8'd0)) begin
          errors++; $display("FAIL ptr_x_h%0d: got %0d", k, pix_ptr_x);
        end
      end
      if (k == 65 || k == 578) begin
        checks++;
        if (vga_blank_n !== 1'b1 || vga_rgb !== side) begin
          errors++; $display("FAIL edge_col_h%0d: got blank_n=%b rgb=%h expected blank_n=1 rgb=%h", k - 2, vga_blank_n, vga_rgb, side);
        end
      end
      if (k == 577) begin
        checks++;
        if (vga_rgb !== 9'd255) begin errors++; $display("FAIL last_win_col: got %h expected 0ff", vga_rgb); end
      end
      @(negedge pix_clk);
    end
  endtask

  task automatic test_scan();
    obs_t o, e, p;
    int terr = 0;
    int hs_fall1 = -1, hs_fall2 = -1, hs_rise1 = -1, vs_fall = -1, vs_rise = -1, fs2 = -1, vb_rise = -1;
    fb_mode = 1'b0;
    do_reset($urandom_range(2, 8));
    p = observe();
    for (int k = 0; k <= FRAME + 2 * LINE; k++) begin
      if (k == FRAME) fb_mode = 1'b1;
      o = observe();
      e = model(k, FRAME);
      checks++;
      if (o !== e) begin
        errors++; terr++;
        $display("FAIL scan k=%0d: got x=%0d y=%0d rgb=%h hs_n=%b vs_n=%b blank_n=%b fs=%b vb=%b expected x=%0d y=%0d rgb=%h hs_n=%b vs_n=%b blank_n=%b fs=%b vb=%b",
                 k, o.x, o.y, o.rgb, o.hs_n, o.vs_n, o.blank_n, o.fs, o.vb, e.x, e.y, e.rgb, e.hs_n, e.vs_n, e.blank_n, e.fs, e.vb);
      end
      if (k == LINE * (VA - 1) + 5) begin
        checks++; if (pix_ptr_y !== 8'd9) begin errors++; $display("FAIL ptr_y_last_row: got %0d expected 9", pix_ptr_y); end
      end
      if (k == LINE * VA + 5) begin
        checks++; if (pix_ptr_y !== 8'd239) begin errors++; $display("FAIL ptr_y_vblank: got %0d expected 239", pix_ptr_y); end
      end
      if (k > 0) begin
        if (p.hs_n && !o.hs_n) begin
          if (hs_fall1 < 0) hs_fall1 = k; else if (hs_fall2 < 0) hs_fall2 = k;
        end
        if (!p.hs_n && o.hs_n && hs_rise1 < 0) hs_rise1 = k;
        if (p.vs_n && !o.vs_n && vs_fall < 0) vs_fall = k;
        if (!p.vs_n && o.vs_n && vs_rise < 0) vs_rise = k;
        if (o.fs && fs2 < 0) fs2 = k;
        if (!p.vb && o.vb && vb_rise < 0) vb_rise = k;
      end
      p = o;
      if (terr >= 20) break;
      @(negedge pix_clk);
    end
    checks++; if (hs_fall1 != 658) begin errors++; $display("FAIL hsync_fall: got %0d expected 658", hs_fall1); end
    checks++; if (hs_rise1 - hs_fall1 != 96) begin errors++; $display("FAIL hsync_width: got %0d expected 96", hs_rise1 - hs_fall1); end
    checks++; if (hs_fall2 - hs_fall1 != LINE) begin errors++; $display("FAIL hsync_period: got %0d expected %0d", hs_fall2 - hs_fall1, LINE); end
    checks++; if (vs_fall != 2 + LINE * (VA + VFP)) begin errors++; $display("FAIL vsync_fall: got %0d expected %0d", vs_fall, 2 + LINE * (VA + VFP)); end
    checks++; if (vs_rise - vs_fall != 1600) begin errors++; $display("FAIL vsync_width: got %0d expected 1600", vs_rise - vs_fall); end
    checks++; if (fs2 != FRAME) begin errors++; $display("FAIL frame_period: got %0d expected %0d", fs2, FRAME); end
    checks++; if (vb_rise != LINE * VA) begin errors++; $display("FAIL vblank_rise: got %0d expected %0d", vb_rise, LINE * VA); end
  endtask

  task automatic test_mid_reset();
    obs_t o, e;
    int terr = 0;
    fb_mode = 1'b1;
    do_reset(4);
    repeat (LINE * 10 + 300) @(negedge pix_clk);
    checks++; if (vga_blank_n !== 1'b1) begin errors++; $display("FAIL pre_reset_active: got blank_n=%b expected 1", vga_blank_n); end
    rst = 1'b1;
    #1;
    checks++;
    if ({vga_rgb, hsync_n, vsync_n, vga_blank_n, frame_start, vblank} !== {9'h000, 5'b11000}) begin
      errors++; $display("FAIL mid_reset_async: got rgb=%h hs_n=%b vs_n=%b blank_n=%b fs=%b vb=%b expected rgb=000 hs_n=1 vs_n=1 blank_n=0 fs=0 vb=0",
                         vga_rgb, hsync_n, vsync_n, vga_blank_n, frame_start, vblank);
    end
    repeat ($urandom_range(2, 6)) @(negedge pix_clk);
    rst = 1'b0;
    @(negedge pix_clk);
    for (int k = 0; k < 2 * LINE + 10; k++) begin
      o = observe();
      e = model(k, 0);
      checks++;
      if (o !== e) begin
        errors++; terr++;
        $display("FAIL restart k=%0d: got x=%0d y=%0d rgb=%h hs_n=%b blank_n=%b fs=%b expected x=%0d y=%0d rgb=%h hs_n=%b blank_n=%b fs=%b",
                 k, o.x, o.y, o.rgb, o.hs_n, o.blank_n, o.fs, e.x, e.y, e.rgb, e.hs_n, e.blank_n, e.fs);
      end
      if (terr >= 20) break;
      @(negedge pix_clk);
    end
  endtask

  task automatic test_random_reset();
    obs_t o, e;
    int terr;
    for (int it = 0; it < 2; it++) begin
      terr = 0;
      fb_mode = 1'b1;
      repeat ($urandom_range(3, FRAME - 1)) @(negedge pix_clk);
      #($urandom_range(0, 4));
      rst = 1'b1;
      #1;
      checks++;
      if ({vga_rgb, hsync_n, vsync_n, vga_blank_n, frame_start, vblank} !== {9'h000, 5'b11000}) begin
        errors++; $display("FAIL rand_reset_async it=%0d: got rgb=%h hs_n=%b vs_n=%b blank_n=%b fs=%b vb=%b", it,
                           vga_rgb, hsync_n, vsync_n, vga_blank_n, frame_start, vblank);
      end
      repeat ($urandom_range(1, 5)) @(negedge pix_clk);
      rst = 1'b0;
      @(negedge pix_clk);
      for (int k = 0; k < 900; k++) begin
        o = observe();
        e = model(k, 0);
        checks++;
        if (o !== e) begin
          errors++; terr++;
          $display("FAIL rand_restart it=%0d k=%0d: got rgb=%h hs_n=%b blank_n=%b fs=%b x=%0d expected rgb=%h hs_n=%b blank_n=%b fs=%b x=%0d",
                   it, k, o.rgb, o.hs_n, o.blank_n, o.fs, o.x, e.rgb, e.hs_n, e.blank_n, e.fs, e.x);
        end
        if (terr >= 20) break;
        @(negedge pix_clk);
      end
    end
  endtask

  initial begin
    for (int y = 0; y < 240; y++)
      for (int x = 0; x < 256; x++)
        fb_img[y][x] = 9'($urandom);
    test_reset();
    test_pointer_map();
    test_scan();
    test_mid_reset();
    test_random_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
